turnstile_controller: RTL and testbench
=======================================

TURNSTILE_CONTROLLER -- requirements
Module: turnstile_controller

Interface
REQ-001 Parameter FARE, default 1, coins required per passage (1..2^CREDIT_W-1).
REQ-002 Parameter CREDIT_W, default 4, width of stored credit.
REQ-003 Parameter COUNT_W, default 16, width of passage counter.
REQ-004 Parameter ALARM_CYCLES, default 8, alarm hold duration in clocks (>=1).
REQ-005 i_clk  input  1  single clock, rising edge active.
REQ-006 i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_coin  input  1  coin sensor level; each 0->1 transition is one coin.
REQ-008 i_push  input  1  arm sensor level; each 0->1 transition is one push.
REQ-009 o_locked  output  1  1 = arm locked.
REQ-010 o_credit  output  CREDIT_W  unspent coins.
REQ-011 o_pass_count  output  COUNT_W  completed passages.
REQ-012 o_coin_reject  output  1  one-clock pulse when a coin is refused.
REQ-013 o_alarm  output  1  forced-push alarm.

Function
REQ-014 The block SHALL register i_coin and i_push each clock; an event SHALL be input high while its previous registered sample is low, so a held level produces exactly one event.
REQ-015 States SHALL be LOCKED, UNLOCKED, ALARM; o_locked SHALL be 0 only in UNLOCKED.
REQ-016 All state, credit and counter updates SHALL take effect at the rising edge where the event is detected (zero added cycles from first high sample).
REQ-017 Coin event: credit SHALL increment by 1; if credit equals 2^CREDIT_W-1, credit SHALL hold and o_coin_reject SHALL pulse for one clock.
REQ-018 LOCKED -> UNLOCKED SHALL occur on the edge where resulting credit >= FARE.
REQ-019 Push event in UNLOCKED: credit SHALL decrease by FARE, o_pass_count SHALL increment (wrapping at 2^COUNT_W), and the state SHALL stay UNLOCKED if remaining credit >= FARE, else go LOCKED.
REQ-020 Simultaneous coin and push events SHALL process the push against pre-coin credit first, then add the coin; the next state SHALL use the final credit.
REQ-021 Push event in LOCKED SHALL leave credit and o_pass_count unchanged (alarm per REQ-027).
REQ-022 In ALARM, coin events SHALL still accumulate credit; push events SHALL be ignored; on expiry the state SHALL go UNLOCKED if credit >= FARE, else LOCKED.

Reset
REQ-023 i_reset_n low SHALL immediately force LOCKED, credit 0, o_pass_count 0, o_coin_reject 0, o_alarm 0, alarm timer 0, without waiting for i_clk.
REQ-024 Registered input samples SHALL reset to 1, so a level already high at reset release produces no event.
REQ-025 Reset asserted mid-passage or mid-alarm SHALL discard all credit and timer state.
REQ-026 Release SHALL be synchronised externally; the block first acts on the first rising edge after deassertion.

Configuration
REQ-027 Macro TURNSTILE_ALARM_EN defined: push event in LOCKED SHALL enter ALARM, assert o_alarm for exactly ALARM_CYCLES clocks, then exit per REQ-022.
REQ-028 Macro TURNSTILE_ALARM_EN undefined: ALARM state and timer SHALL not exist, push in LOCKED SHALL be ignored, and o_alarm SHALL be constant 0.

Verification
REQ-029 FARE=1: reset 10 clocks, release -> o_locked=1, o_credit=0; raise i_coin held -> o_locked=0, o_credit=0->1->... stays 1 (one event only).
REQ-030 FARE=2: two coin pulses -> o_locked=1 after first, 0 after second; push pulse -> o_locked=1, o_credit=0, o_pass_count=1.
REQ-031 FARE=1, CREDIT_W=2: five coin pulses -> o_credit=3, o_coin_reject pulses on 4th and 5th; three pushes -> o_pass_count=3, o_locked=1 after third only.
REQ-032 FARE=1, credit 1, coin and push rise same clock -> o_pass_count=1, o_credit=1, o_locked stays 0.
REQ-033 TURNSTILE_ALARM_EN, ALARM_CYCLES=8: push while locked -> o_alarm high exactly 8 clocks, then o_locked=1; without macro same stimulus -> o_alarm=0, o_locked=1.
REQ-034 Unlocked with credit 3, pull i_reset_n low between clock edges -> o_locked=1, o_credit=0, o_pass_count=0 before next rising edge; held-high i_coin at release produces no coin.

Source files
------------

// File: rtl/turnstile_controller.sv
// Coin-operated turnstile: edge-detected coin/push sensors, credit store and passage counter.
// Defining TURNSTILE_ALARM_EN adds the forced-push ALARM state and its hold timer.
module turnstile_controller #(
    parameter int FARE         = 1,
    parameter int CREDIT_W     = 4,
    parameter int COUNT_W      = 16,
    parameter int ALARM_CYCLES = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_coin,
    input  logic                i_push,
    output logic                o_locked,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [COUNT_W-1:0]  o_pass_count,
    output logic                o_coin_reject,
    output logic                o_alarm,
    output logic [1:0]          o_state
);

    localparam logic [CREDIT_W-1:0] FARE_C     = CREDIT_W'(FARE);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    if (FARE < 1 || FARE >= (1 << CREDIT_W)) begin : g_bad_fare
        $error("turnstile_controller: FARE out of range for CREDIT_W");
    end
    if (ALARM_CYCLES < 1) begin : g_bad_alarm
        $error("turnstile_controller: ALARM_CYCLES must be at least 1");
    end

`ifdef TURNSTILE_ALARM_EN
    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_ALARM    = 2'd2
    } state_t;

    localparam int TIMER_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ALARM_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, credit_mid;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                reject_q, reject_d;
    logic                coin_q, push_q;
    logic                coin_ev, push_ev;
    logic                unlock_ok;

    // Samples reset high so a sensor already active at reset release is not an event.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            coin_q <= 1'b1;
            push_q <= 1'b1;
        end else begin
            coin_q <= i_coin;
            push_q <= i_push;
        end
    end

    assign coin_ev = i_coin & ~coin_q;
    assign push_ev = i_push & ~push_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_LOCKED;
            credit_q <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
`ifdef TURNSTILE_ALARM_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            reject_q <= reject_d;
`ifdef TURNSTILE_ALARM_EN
            timer_q  <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reject_d   = 1'b0;
        credit_mid = credit_q;
`ifdef TURNSTILE_ALARM_EN
        timer_d    = timer_q;
`endif
        // A passage is charged against the credit held before any same-cycle coin.
        if (push_ev && state_q == S_UNLOCKED) begin
            credit_mid = credit_q - FARE_C;
            count_d    = count_q + COUNT_W'(1);
        end

        credit_d = credit_mid;
        if (coin_ev) begin
            if (credit_mid == CREDIT_MAX) begin
                reject_d = 1'b1;
            end else begin
                credit_d = credit_mid + CREDIT_W'(1);
            end
        end

        unlock_ok = (credit_d >= FARE_C);

        case (state_q)
            S_LOCKED: begin
`ifdef TURNSTILE_ALARM_EN
                if (push_ev) begin
                    state_d = S_ALARM;
                    timer_d = TIMER_LAST;
                end else if (unlock_ok) begin
                    state_d = S_UNLOCKED;
                end
`else
                if (unlock_ok) begin
                    state_d = S_UNLOCKED;
                end
`endif
            end
            S_UNLOCKED: state_d = unlock_ok ? S_UNLOCKED : S_LOCKED;
`ifdef TURNSTILE_ALARM_EN
            S_ALARM: begin
                if (timer_q == '0) begin
                    state_d = unlock_ok ? S_UNLOCKED : S_LOCKED;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
`endif
            default: state_d = S_LOCKED;
        endcase
    end

    assign o_locked      = (state_q != S_UNLOCKED);
    assign o_credit      = credit_q;
    assign o_pass_count  = count_q;
    assign o_coin_reject = reject_q;
    assign o_state       = state_q;
`ifdef TURNSTILE_ALARM_EN
    assign o_alarm       = (state_q == S_ALARM);
`else
    assign o_alarm       = 1'b0;
`endif

endmodule

// File: tb/tb_turnstile_controller.sv
// Bench for turnstile_controller: two instances (FARE=1/CREDIT_W=2 and FARE=2/CREDIT_W=4)
// driven by shared sensors, checked cycle by cycle against a behavioural model.
module tb_turnstile_controller;

    localparam int W       = 23;
    localparam int FARE_A  = 1;
    localparam int CMAX_A  = 3;
    localparam int FARE_B  = 2;
    localparam int CMAX_B  = 15;
    localparam int ALARM_N = 8;
`ifdef TURNSTILE_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        coin_s;
    logic        push_s;

    logic        locked_a, rej_a, alarm_a;
    logic [1:0]  credit_a;
    logic [15:0] count_a;
    logic [1:0]  st_a;
    logic        locked_b, rej_b, alarm_b;
    logic [3:0]  credit_b;
    logic [15:0] count_b;
    logic [1:0]  st_b;

    turnstile_controller #(
        .FARE(FARE_A), .CREDIT_W(2), .COUNT_W(16), .ALARM_CYCLES(ALARM_N)
    ) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_coin(coin_s), .i_push(push_s),
        .o_locked(locked_a), .o_credit(credit_a), .o_pass_count(count_a),
        .o_coin_reject(rej_a), .o_alarm(alarm_a), .o_state(st_a)
    );

    turnstile_controller #(
        .FARE(FARE_B), .CREDIT_W(4), .COUNT_W(16), .ALARM_CYCLES(ALARM_N)
    ) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_coin(coin_s), .i_push(push_s),
        .o_locked(locked_b), .o_credit(credit_b), .o_pass_count(count_b),
        .o_coin_reject(rej_b), .o_alarm(alarm_b), .o_state(st_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model state, index 0 = instance a, 1 = instance b
    int   m_credit[2];
    int   m_count[2];
    int   m_alarm[2];
    logic m_locked[2];
    logic m_rej[2];
    logic m_pc, m_pp;

    function automatic logic [W-1:0] pack(input logic l, input logic a, input logic r,
                                          input logic [3:0] c, input logic [15:0] n);
        return {l, a, r, c, n};
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got{lock,alarm,rej,credit,count}=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_expected();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(pack(m_locked[k], (m_alarm[k] > 0), m_rej[k],
                                 4'(m_credit[k]), 16'(m_count[k])));
        end
    endtask

    task automatic compare_outputs(input string phase);
        logic [W-1:0] e;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_eq({phase, "_a"}, pack(locked_a, alarm_a, rej_a, {2'b00, credit_a}, count_a), e);
            e = exp_q.pop_front();
            check_eq({phase, "_b"}, pack(locked_b, alarm_b, rej_b, credit_b, count_b), e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_credit[k] = 0;
            m_count[k]  = 0;
            m_alarm[k]  = 0;
            m_locked[k] = 1'b1;
            m_rej[k]    = 1'b0;
        end
        m_pc = 1'b1;
        m_pp = 1'b1;
        push_expected();
    endtask

    task automatic coin_in(input int k, input int cmax, input logic ce);
        if (ce) begin
            if (m_credit[k] == cmax) m_rej[k] = 1'b1;
            else m_credit[k] = m_credit[k] + 1;
        end
    endtask

    task automatic model_step(input logic coin, input logic push);
        logic ce, pe;
        ce = coin & ~m_pc;
        pe = push & ~m_pp;
        m_pc = coin;
        m_pp = push;
        for (int k = 0; k < 2; k++) begin
            int fare;
            int cmax;
            fare = (k == 0) ? FARE_A : FARE_B;
            cmax = (k == 0) ? CMAX_A : CMAX_B;
            m_rej[k] = 1'b0;
            if (m_alarm[k] > 0) begin
                coin_in(k, cmax, ce);
                m_alarm[k] = m_alarm[k] - 1;
                if (m_alarm[k] == 0) m_locked[k] = (m_credit[k] < fare);
            end else if (!m_locked[k]) begin
                if (pe) begin
                    m_credit[k] = m_credit[k] - fare;
                    m_count[k]  = (m_count[k] + 1) % 65536;
                end
                coin_in(k, cmax, ce);
                m_locked[k] = (m_credit[k] < fare);
            end else begin
                coin_in(k, cmax, ce);
                if (pe && ALARM_ON) m_alarm[k] = ALARM_N;
                else m_locked[k] = (m_credit[k] < fare);
            end
        end
        push_expected();
    endtask

    // Driver tasks: entered and left at a falling edge
    task automatic drive(input logic coin, input logic push);
        coin_s = coin;
        push_s = push;
        model_step(coin, push);
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs("cycle");
        @(negedge clk);
    endtask

    task automatic pulse(input logic coin, input logic push);
        drive(coin, push);
        drive(1'b0, 1'b0);
    endtask

    // Reset lands between clock edges and is checked before the next rising edge.
    task automatic apply_reset(input int hold, input logic coin_level);
        #2;
        coin_s = coin_level;
        push_s = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        compare_outputs("async_reset");
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        coin_s = 1'b0;
        push_s = 1'b0;
        @(negedge clk);
        apply_reset(10, 1'b0);
        drive(1'b0, 1'b0);

        // Held coin counts once; then single coins, a passage, saturation, passages to empty
        repeat (4) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (4) pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0);

        // Coin and push rising together
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        repeat (12) drive(1'b0, 1'b0);

        // Random sensor activity
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (12) drive(1'b0, 1'b0);

        // Reset while unlocked with a coin held high through release
        repeat (3) pulse(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        apply_reset(3, 1'b1);
        repeat (4) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        pulse(1'b1, 1'b0);

        // Push while locked, then reset during any alarm
        pulse(1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0);
        apply_reset(2, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
